mem_port_arbiter: RTL and testbench

- Shares one external memory bus between the core's instruction-fetch port (mem_i_*) and data port (mem_d_*).
- Arbitrates round-robin and allows one outstanding bus transaction at a time.
- Routes each response, with its tag, back to the requester that owns it, and applies a response timeout.
- Sits between the core and the memory model in the core testbench/top.

---
 rtl/mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory bus between the core's instruction-fetch port
// (mem_i_*) and data port (mem_d_*). Requests are arbitrated round-robin and
// only one bus transaction is outstanding at a time. Each response, with its
// tag, is routed back to the requester that owns it. A response timeout
// forces an error response if the bus never acknowledges.
//
// Parameters
//   TIMEOUT_CYCLES : ack-eligible cycles before an error response is forced
//                    (>= 1). The bus-accept cycle is the first of them.
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES.
//
// Ports
//   clk, rst               : clock, synchronous active-low reset
//   mem_i_rd_w/pc_w        : fetch request / address (held until accepted)
//   mem_i_accept_w         : fetch request taken this cycle (IDLE only)
//   mem_i_valid_w/error_w/inst_w : one-cycle fetch response + error + data
//   mem_d_rd_w/wr_w        : data read / byte write enables
//   mem_d_flush_w/invalidate_w/writeback_w : cache-maintenance ops
//   mem_d_addr_w/data_wr_w/req_tag_w : data address, write data, tag
//   mem_d_accept_w         : data request taken this cycle (IDLE only)
//   mem_d_ack_w/error_w/data_rd_w/resp_tag_w : one-cycle data response
//   bus_rd_o/wr_o/addr_o/data_wr_o : registered bus command
//   bus_accept_i           : bus took the command
//   bus_ack_i/error_i/data_rd_i : bus response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_i_rd_w,
    input  logic [31:0] mem_i_pc_w,
    output logic        mem_i_accept_w,
    output logic        mem_i_valid_w,
    output logic        mem_i_error_w,
    output logic [31:0] mem_i_inst_w,

    input  logic        mem_d_rd_w,
    input  logic [3:0]  mem_d_wr_w,
    input  logic        mem_d_flush_w,
    input  logic        mem_d_invalidate_w,
    input  logic        mem_d_writeback_w,
    input  logic [31:0] mem_d_addr_w,
    input  logic [31:0] mem_d_data_wr_w,
    input  logic [10:0] mem_d_req_tag_w,
    output logic        mem_d_accept_w,
    output logic        mem_d_ack_w,
    output logic        mem_d_error_w,
    output logic [31:0] mem_d_data_rd_w,
    output logic [10:0] mem_d_resp_tag_w,

    output logic        bus_rd_o,
    output logic [3:0]  bus_wr_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_wr_o,
    input  logic        bus_accept_i,
    input  logic        bus_ack_i,
    input  logic        bus_error_i,
    input  logic [31:0] bus_data_rd_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAINT,
        ST_BUS_REQ,
        ST_BUS_RESP,
        ST_RESPOND
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // The accept cycle is already the first ack-eligible cycle, so BUS_RESP
    // gives up after TIMEOUT_CYCLES-1 further cycles; the error strobe then
    // lands exactly TIMEOUT_CYCLES cycles after the bus accept.
    localparam int unsigned    LAST_WAIT_INT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] LAST_WAIT   = LAST_WAIT_INT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [10:0]       tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              bus_rd_q, bus_rd_d;
    logic [3:0]        bus_wr_q, bus_wr_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_data_q, bus_data_d;

    logic              i_valid_q, i_valid_d;
    logic              i_error_q, i_error_d;
    logic [31:0]       i_inst_q, i_inst_d;
    logic              d_ack_q, d_ack_d;
    logic              d_error_q, d_error_d;
    logic [31:0]       d_data_q, d_data_d;
    logic [10:0]       d_tag_q, d_tag_d;

    // Response staging for the current cycle; registered into the owner's
    // output strobe so it appears in the following cycle.
    logic              do_resp;
    logic              resp_err;
    logic [31:0]       resp_data;

    // Request decode and round-robin choice
    logic i_req, d_bus_req, d_maint, d_req;
    logic grant_i, grant_d, in_idle;

    assign i_req     = mem_i_rd_w;
    assign d_bus_req = mem_d_rd_w | (|mem_d_wr_w);
    assign d_maint   = (mem_d_flush_w | mem_d_invalidate_w | mem_d_writeback_w) & ~d_bus_req;
    assign d_req     = d_bus_req | d_maint;
    assign grant_i   = i_req & (~d_req | (last_grant_q == OWNER_D));
    assign grant_d   = d_req & ~grant_i;

    // Accept is combinational; masking with rst keeps a request from looking
    // taken while reset is holding the state machine in IDLE.
    assign in_idle        = (state_q == ST_IDLE) & rst;
    assign mem_i_accept_w = in_idle & grant_i;
    assign mem_d_accept_w = in_idle & grant_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        bus_rd_d     = bus_rd_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        i_valid_d    = 1'b0;
        i_error_d    = i_error_q;
        i_inst_d     = i_inst_q;
        d_ack_d      = 1'b0;
        d_error_d    = d_error_q;
        d_data_d     = d_data_q;
        d_tag_d      = d_tag_q;
        do_resp      = 1'b0;
        resp_err     = 1'b0;
        resp_data    = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    owner_d      = OWNER_I;
                    last_grant_d = OWNER_I;
                    bus_rd_d     = 1'b1;
                    bus_wr_d     = 4'h0;
                    bus_addr_d   = mem_i_pc_w;
                    bus_data_d   = 32'h0;
                    state_d      = ST_BUS_REQ;
                end else if (grant_d) begin
                    owner_d      = OWNER_D;
                    last_grant_d = OWNER_D;
                    tag_d        = mem_d_req_tag_w;
                    if (d_bus_req) begin
                        // A write outranks a simultaneous read.
                        bus_wr_d   = mem_d_wr_w;
                        bus_rd_d   = ~(|mem_d_wr_w);
                        bus_addr_d = mem_d_addr_w;
                        bus_data_d = mem_d_data_wr_w;
                        state_d    = ST_BUS_REQ;
                    end else begin
                        state_d    = ST_MAINT;
                    end
                end
            end

            ST_MAINT: begin
                do_resp = 1'b1;
                state_d = ST_IDLE;
            end

            ST_BUS_REQ: begin
                if (bus_accept_i) begin
                    bus_rd_d = 1'b0;
                    bus_wr_d = 4'h0;
                    cnt_d    = '0;
                    if (bus_ack_i) begin
                        do_resp   = 1'b1;
                        resp_data = bus_data_rd_i;
                        resp_err  = bus_error_i;
                        state_d   = ST_RESPOND;
                    end else if (TIMEOUT_CYCLES == 1) begin
                        do_resp  = 1'b1;
                        resp_err = 1'b1;
                        state_d  = ST_RESPOND;
                    end else begin
                        state_d  = ST_BUS_RESP;
                    end
                end
            end

            ST_BUS_RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus_ack_i) begin
                    do_resp   = 1'b1;
                    resp_data = bus_data_rd_i;
                    resp_err  = bus_error_i;
                    state_d   = ST_RESPOND;
                end else if (cnt_q == LAST_WAIT) begin
                    do_resp  = 1'b1;
                    resp_err = 1'b1;
                    state_d  = ST_RESPOND;
                end
            end

            ST_RESPOND: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_resp) begin
            if (owner_q == OWNER_I) begin
                i_valid_d = 1'b1;
                i_inst_d  = resp_data;
                i_error_d = resp_err;
            end else begin
                d_ack_d   = 1'b1;
                d_data_d  = resp_data;
                d_error_d = resp_err;
                d_tag_d   = tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_I;
            last_grant_q <= OWNER_D;
            tag_q        <= '0;
            cnt_q        <= '0;
            bus_rd_q     <= 1'b0;
            bus_wr_q     <= '0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            i_valid_q    <= 1'b0;
            i_error_q    <= 1'b0;
            i_inst_q     <= '0;
            d_ack_q      <= 1'b0;
            d_error_q    <= 1'b0;
            d_data_q     <= '0;
            d_tag_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            bus_rd_q     <= bus_rd_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            i_valid_q    <= i_valid_d;
            i_error_q    <= i_error_d;
            i_inst_q     <= i_inst_d;
            d_ack_q      <= d_ack_d;
            d_error_q    <= d_error_d;
            d_data_q     <= d_data_d;
            d_tag_q      <= d_tag_d;
        end
    end

    assign bus_rd_o         = bus_rd_q;
    assign bus_wr_o         = bus_wr_q;
    assign bus_addr_o       = bus_addr_q;
    assign bus_data_wr_o    = bus_data_q;
    assign mem_i_valid_w    = i_valid_q;
    assign mem_i_error_w    = i_error_q;
    assign mem_i_inst_w     = i_inst_q;
    assign mem_d_ack_w      = d_ack_q;
    assign mem_d_error_w    = d_error_q;
    assign mem_d_data_rd_w  = d_data_q;
    assign mem_d_resp_tag_w = d_tag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES=8. A bus responder
// answers commands after a programmable latency; expected responses are
// queued when a request is accepted and compared when a strobe appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int          TO = 8;
    localparam logic [31:0] K  = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_rd_w;
    logic [31:0] mem_i_pc_w;
    logic        mem_i_accept_w, mem_i_valid_w, mem_i_error_w;
    logic [31:0] mem_i_inst_w;
    logic        mem_d_rd_w;
    logic [3:0]  mem_d_wr_w;
    logic        mem_d_flush_w, mem_d_invalidate_w, mem_d_writeback_w;
    logic [31:0] mem_d_addr_w, mem_d_data_wr_w;
    logic [10:0] mem_d_req_tag_w;
    logic        mem_d_accept_w, mem_d_ack_w, mem_d_error_w;
    logic [31:0] mem_d_data_rd_w;
    logic [10:0] mem_d_resp_tag_w;
    logic        bus_rd_o;
    logic [3:0]  bus_wr_o;
    logic [31:0] bus_addr_o, bus_data_wr_o;
    logic        bus_accept_i, bus_ack_i, bus_error_i;
    logic [31:0] bus_data_rd_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_i_rd_w         (mem_i_rd_w),
        .mem_i_pc_w         (mem_i_pc_w),
        .mem_i_accept_w     (mem_i_accept_w),
        .mem_i_valid_w      (mem_i_valid_w),
        .mem_i_error_w      (mem_i_error_w),
        .mem_i_inst_w       (mem_i_inst_w),
        .mem_d_rd_w         (mem_d_rd_w),
        .mem_d_wr_w         (mem_d_wr_w),
        .mem_d_flush_w      (mem_d_flush_w),
        .mem_d_invalidate_w (mem_d_invalidate_w),
        .mem_d_writeback_w  (mem_d_writeback_w),
        .mem_d_addr_w       (mem_d_addr_w),
        .mem_d_data_wr_w    (mem_d_data_wr_w),
        .mem_d_req_tag_w    (mem_d_req_tag_w),
        .mem_d_accept_w     (mem_d_accept_w),
        .mem_d_ack_w        (mem_d_ack_w),
        .mem_d_error_w      (mem_d_error_w),
        .mem_d_data_rd_w    (mem_d_data_rd_w),
        .mem_d_resp_tag_w   (mem_d_resp_tag_w),
        .bus_rd_o           (bus_rd_o),
        .bus_wr_o           (bus_wr_o),
        .bus_addr_o         (bus_addr_o),
        .bus_data_wr_o      (bus_data_wr_o),
        .bus_accept_i       (bus_accept_i),
        .bus_ack_i          (bus_ack_i),
        .bus_error_i        (bus_error_i),
        .bus_data_rd_i      (bus_data_rd_i)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [10:0] tag;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];
    exp_t e_i, e_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{mem_i_accept_w, mem_i_valid_w, mem_i_error_w, mem_i_inst_w,
                 mem_d_accept_w, mem_d_ack_w, mem_d_error_w, mem_d_data_rd_w,
                 mem_d_resp_tag_w, bus_rd_o, bus_wr_o, bus_addr_o, bus_data_wr_o};
    endfunction

    // ---------------- bus responder ----------------
    int          lat = 1;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    bit          busy;
    int          cnt;
    logic [31:0] pend_data;
    logic        cap_rd;
    logic [3:0]  cap_wr;
    logic [31:0] cap_addr, cap_data;
    int          bus_acc_cyc = 0;
    int          n_bus_cmds  = 0;

    initial begin : responder
        bus_accept_i  = 1'b0;
        bus_ack_i     = 1'b0;
        bus_error_i   = 1'b0;
        bus_data_rd_i = 32'hBAD0_BAD0;
        busy          = 1'b0;
        cnt           = 0;
        forever begin
            @(negedge clk);
            bus_accept_i  = 1'b0;
            bus_ack_i     = 1'b0;
            bus_data_rd_i = 32'hBAD0_BAD0;
            if (rst !== 1'b1) begin
                busy = 1'b0;
            end else if (busy) begin
                check("no_cmd_while_outstanding", {bus_rd_o, bus_wr_o}, 0);
                if (cnt == 0) begin
                    bus_ack_i     = 1'b1;
                    bus_data_rd_i = pend_data;
                    busy          = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (bus_rd_o || bus_wr_o != 4'h0) begin
                cap_rd       = bus_rd_o;
                cap_wr       = bus_wr_o;
                cap_addr     = bus_addr_o;
                cap_data     = bus_data_wr_o;
                n_bus_cmds++;
                bus_acc_cyc  = cyc;
                bus_accept_i = 1'b1;
                pend_data    = fixed_en ? fixed_data : (bus_addr_o ^ K);
                if (lat == 0) begin
                    bus_ack_i     = 1'b1;
                    bus_data_rd_i = pend_data;
                end else begin
                    busy = 1'b1;
                    cnt  = lat - 1;
                end
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    int i_strobe_cyc = 0, d_strobe_cyc = 0;
    int n_i_strobes  = 0, n_d_strobes  = 0;

    always @(negedge clk) begin
        if (mem_i_valid_w === 1'b1) begin
            n_i_strobes++;
            i_strobe_cyc = cyc;
            if (exp_i.size() == 0) begin
                check("i_spurious_valid", mem_i_valid_w, 0);
            end else begin
                e_i = exp_i.pop_front();
                check("i_inst", mem_i_inst_w, e_i.data);
                check("i_error", mem_i_error_w, e_i.err);
            end
        end
        if (mem_d_ack_w === 1'b1) begin
            n_d_strobes++;
            d_strobe_cyc = cyc;
            if (exp_d.size() == 0) begin
                check("d_spurious_ack", mem_d_ack_w, 0);
            end else begin
                e_d = exp_d.pop_front();
                check("d_data", mem_d_data_rd_w, e_d.data);
                check("d_error", mem_d_error_w, e_d.err);
                check("d_tag", mem_d_resp_tag_w, e_d.tag);
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic issue_i(input logic [31:0] pc, input bit push,
                           input logic [31:0] edata, input logic eerr, output int waited);
        @(negedge clk);
        mem_i_rd_w = 1'b1;
        mem_i_pc_w = pc;
        waited = 0;
        #1;
        while (mem_i_accept_w !== 1'b1 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("i_accept_seen", mem_i_accept_w, 1);
        if (mem_i_accept_w === 1'b1 && push) exp_i.push_back({edata, eerr, 11'h0});
        @(negedge clk);
        mem_i_rd_w = 1'b0;
    endtask

    task automatic issue_d(input logic rd, input logic [3:0] wr, input logic fl,
                           input logic inv, input logic wb, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [10:0] tag,
                           input logic [31:0] edata, input logic eerr, output int waited);
        @(negedge clk);
        mem_d_rd_w = rd; mem_d_wr_w = wr; mem_d_flush_w = fl;
        mem_d_invalidate_w = inv; mem_d_writeback_w = wb;
        mem_d_addr_w = addr; mem_d_data_wr_w = wdata; mem_d_req_tag_w = tag;
        waited = 0;
        #1;
        while (mem_d_accept_w !== 1'b1 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("d_accept_seen", mem_d_accept_w, 1);
        if (mem_d_accept_w === 1'b1) exp_d.push_back({edata, eerr, tag});
        @(negedge clk);
        mem_d_rd_w = 1'b0; mem_d_wr_w = 4'h0; mem_d_flush_w = 1'b0;
        mem_d_invalidate_w = 1'b0; mem_d_writeback_w = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while ((exp_i.size() != 0 || exp_d.size() != 0) && w < 60) begin
            @(negedge clk);
            w++;
        end
        check(tag, (exp_i.size() == 0) && (exp_d.size() == 0), 1);
        exp_i.delete();
        exp_d.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs_zero", any_out(), 0);
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int w;
    int bi, bd, cmds0;
    int grants;
    int order[4];
    int gcyc[4];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        mem_i_rd_w = 1'b0; mem_i_pc_w = 32'h0;
        mem_d_rd_w = 1'b0; mem_d_wr_w = 4'h0; mem_d_flush_w = 1'b0;
        mem_d_invalidate_w = 1'b0; mem_d_writeback_w = 1'b0;
        mem_d_addr_w = 32'h0; mem_d_data_wr_w = 32'h0; mem_d_req_tag_w = 11'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs_zero_init", any_out(), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("idle_outputs_zero", any_out(), 0);

        // 1: lone fetch, bus acks 3 cycles after accept
        lat = 3; fixed_en = 1'b1; fixed_data = 32'h0010_0093;
        bi = n_i_strobes; bd = n_d_strobes;
        issue_i(32'h0000_0100, 1'b1, 32'h0010_0093, 1'b0, w);
        check("t1_accept_cycle0", w, 0);
        drain("t1_drain");
        fixed_en = 1'b0;
        check("t1_bus_rd", cap_rd, 1);
        check("t1_bus_wr", cap_wr, 0);
        check("t1_bus_addr", cap_addr, 32'h0000_0100);
        check("t1_i_strobes", n_i_strobes - bi, 1);
        check("t1_d_strobes", n_d_strobes - bd, 0);
        check("t1_latency", i_strobe_cyc - bus_acc_cyc, 4);

        // 2: D write (rd also set; write wins)
        lat = 2;
        bd = n_d_strobes;
        issue_d(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF,
                11'h155, 32'h8000_0004 ^ K, 1'b0, w);
        drain("t2_drain");
        check("t2_bus_rd", cap_rd, 0);
        check("t2_bus_wr", cap_wr, 4'b0011);
        check("t2_bus_addr", cap_addr, 32'h8000_0004);
        check("t2_bus_data", cap_data, 32'hDEAD_BEEF);
        check("t2_d_strobes", n_d_strobes - bd, 1);

        // 3: continuous contention from reset, zero-wait bus
        apply_reset();
        lat = 0;
        cmds0 = n_bus_cmds;
        grants = 0;
        @(negedge clk);
        mem_i_rd_w = 1'b1; mem_i_pc_w = 32'h0000_0200;
        mem_d_rd_w = 1'b1; mem_d_addr_w = 32'h0000_0300; mem_d_req_tag_w = 11'h0AA;
        for (int k = 0; k < 200 && grants < 4; k++) begin
            #1;
            if (mem_i_accept_w === 1'b1 || mem_d_accept_w === 1'b1) begin
                check("t3_single_accept", mem_i_accept_w & mem_d_accept_w, 0);
                gcyc[grants] = cyc;
                if (mem_i_accept_w === 1'b1) begin
                    order[grants] = 0;
                    exp_i.push_back({32'h0000_0200 ^ K, 1'b0, 11'h0});
                end else begin
                    order[grants] = 1;
                    exp_d.push_back({32'h0000_0300 ^ K, 1'b0, 11'h0AA});
                end
                grants++;
            end
            @(negedge clk);
        end
        mem_i_rd_w = 1'b0; mem_d_rd_w = 1'b0;
        check("t3_grants", grants, 4);
        check("t3_order0", order[0], 0);
        check("t3_order1", order[1], 1);
        check("t3_order2", order[2], 0);
        check("t3_order3", order[3], 1);
        check("t3_round_trip", gcyc[1] - gcyc[0], 3);
        drain("t3_drain");
        check("t3_bus_cmds", n_bus_cmds - cmds0, 4);

        // 4: invalidate maintenance op, no bus traffic
        cmds0 = n_bus_cmds;
        issue_d(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 11'h7FF,
                32'h0, 1'b0, w);
        #1;
        check("t4_ack_not_c1", mem_d_ack_w, 0);
        @(negedge clk);
        #1;
        check("t4_ack_c2", mem_d_ack_w, 1);
        drain("t4_drain");
        check("t4_no_bus_cmd", n_bus_cmds - cmds0, 0);

        // 5: ack arrives too late -> timeout error, late ack ignored
        lat = 10;
        bi = n_i_strobes;
        issue_i(32'h0000_0400, 1'b1, 32'h0, 1'b1, w);
        drain("t5_drain");
        repeat (6) @(negedge clk);
        check("t5_timeout_latency", i_strobe_cyc - bus_acc_cyc, TO);
        check("t5_single_strobe", n_i_strobes - bi, 1);

        // 6: reset while waiting for the bus response
        lat = 10;
        bi = n_i_strobes;
        issue_i(32'h0000_0500, 1'b0, 32'h0, 1'b0, w);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t6_outputs_zero", any_out(), 0);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_no_aborted_resp", n_i_strobes - bi, 0);
        lat = 1;
        issue_i(32'h0000_0600, 1'b1, 32'h0000_0600 ^ K, 1'b0, w);
        drain("t6_drain");
        check("t6_new_fetch", n_i_strobes - bi, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
